// File: rtl/alarm_arming_controller.sv
// Arming / siren sequencer: exit delay, armed, entry delay and siren states with fire override.
// Latency: inputs sampled on a rising edge; state and outputs are visible after that edge.
// Ports: clk, reset (async active-low); arm_req/auth_status/alarm_in/fire_in levels in;
//        armed/siren/beep/state/event_count out, all registered or decoded from registered state.
module alarm_arming_controller #(
   parameter int EXIT_DELAY  = 16,
   parameter int ENTRY_DELAY = 16,
   parameter int SIREN_TIME  = 64,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arm_req,
   input  logic       auth_status,
   input  logic       alarm_in,
   input  logic       fire_in,
   output logic       armed,
   output logic       siren,
   output logic       beep,
   output logic [2:0] state,
   output logic [7:0] event_count
);

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      EXIT     = 3'd1,
      ARMED    = 3'd2,
      ENTRY    = 3'd3,
      SIREN    = 3'd4
   } state_t;

   // Counters load N-1 so a timed state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

   state_t           st;
   state_t           st_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ret_armed;
   logic             ret_nxt;
   logic             auth_q;
   logic             auth_rise;
   logic             ev_inc;
   logic             cnt_zero;

   assign auth_rise = auth_status & ~auth_q;
   assign cnt_zero  = (cnt == '0);
   assign state     = st;

   always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      ret_nxt = ret_armed;
      ev_inc  = 1'b0;
      if (st > SIREN) begin
         // Unreachable codes fall back to the safe state.
         st_nxt = DISARMED;
      end else if (fire_in && (st != SIREN)) begin
         st_nxt  = SIREN;
         cnt_nxt = SIREN_LOAD;
         ev_inc  = 1'b1;
         ret_nxt = (st == ARMED) || (st == ENTRY);
      end else begin
         case (st)
            DISARMED: begin
               if (arm_req && auth_status) begin
                  st_nxt  = EXIT;
                  cnt_nxt = EXIT_LOAD;
               end
            end
            EXIT: begin
               if (auth_rise)     st_nxt = DISARMED;
               else if (cnt_zero) st_nxt = ARMED;
               else               cnt_nxt = cnt - 1'b1;
            end
            ARMED: begin
               if (auth_rise) begin
                  st_nxt = DISARMED;
               end else if (alarm_in) begin
                  st_nxt  = ENTRY;
                  cnt_nxt = ENTRY_LOAD;
               end
            end
            ENTRY: begin
               // A dropped alarm_in does not cancel the grace period; only a user does.
               if (auth_rise) begin
                  st_nxt = DISARMED;
               end else if (cnt_zero) begin
                  st_nxt  = SIREN;
                  cnt_nxt = SIREN_LOAD;
                  ret_nxt = 1'b1;
                  ev_inc  = 1'b1;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            SIREN: begin
               // A user acknowledging during the siren never returns to ARMED, even if
               // fire keeps the siren on for now.
               if (auth_rise) ret_nxt = 1'b0;
               if (fire_in) begin
                  // Timer is spent while fire persists so the siren stops as soon as it clears.
                  cnt_nxt = '0;
               end else if (auth_rise) begin
                  st_nxt = DISARMED;
               end else if (cnt_zero) begin
                  st_nxt = ret_armed ? ARMED : DISARMED;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: st_nxt = DISARMED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st          <= DISARMED;
         cnt         <= '0;
         ret_armed   <= 1'b0;
         auth_q      <= 1'b0;
         event_count <= 8'd0;
         armed       <= 1'b0;
         siren       <= 1'b0;
         beep        <= 1'b0;
      end else begin
         st        <= st_nxt;
         cnt       <= cnt_nxt;
         ret_armed <= ret_nxt;
         auth_q    <= auth_status;
         if (ev_inc && (event_count != 8'hFF)) event_count <= event_count + 8'd1;
         armed <= (st_nxt == ARMED) || (st_nxt == ENTRY);
         siren <= (st_nxt == SIREN);
         beep  <= (st_nxt == EXIT) || (st_nxt == ENTRY);
      end
   end

endmodule
